// File: rtl/feature_map_streamer.sv
`default_nettype none
// ============================================================================
// Module   : feature_map_streamer
// Brief    : Reads an image from memory in raster order and streams it to the
//            convolution input; FEEDER_FLUSH_EN appends Flush_Count zero pixels.
// Revision : 1.0
// ============================================================================
module feature_map_streamer #(
  parameter int IMG_Width   = 4,
  parameter int IMG_Height  = 4,
  parameter int Datawidth   = 32,
  parameter int Addrwidth   = 16,
  parameter int Flush_Count = IMG_Width + 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic                 Start,
  input  logic [Addrwidth-1:0] Base_Addr,
  input  logic                 Hold,
  output logic                 Mem_RdEn,
  output logic [Addrwidth-1:0] Mem_Addr,
  input  logic [Datawidth-1:0] Mem_Data,
  output logic [Datawidth-1:0] Out,
  output logic                 Valid_OUT,
  output logic                 Busy,
  output logic                 Done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    FLUSH  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int                 c_NUM_PIX  = IMG_Width * IMG_Height;
  localparam int                 c_PIX_W    = (c_NUM_PIX > 1) ? $clog2(c_NUM_PIX) : 1;
  localparam logic [c_PIX_W-1:0] c_LAST_PIX = c_PIX_W'(c_NUM_PIX - 1);

`ifdef FEEDER_FLUSH_EN
  localparam int                c_FL_W      = (Flush_Count > 1) ? $clog2(Flush_Count) : 1;
  localparam logic [c_FL_W-1:0] c_LAST_FL   = c_FL_W'(Flush_Count - 1);
  localparam state_t            c_AFTER_RD  = (Flush_Count > 0) ? FLUSH : FINISH;
  logic [c_FL_W-1:0]            r_flush_cnt;
`else
  localparam state_t            c_AFTER_RD  = FINISH;
`endif

  state_t               r_state;
  logic [Addrwidth-1:0] r_addr;
  logic [c_PIX_W-1:0]   r_pix_cnt;
  logic                 r_s1_valid;
  logic                 r_s1_zero;

  // r_addr tracks base + pixel counter directly, so it wraps with the address width
  assign Mem_RdEn = (r_state == READ) && !Hold;
  assign Mem_Addr = r_addr;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_pix_cnt  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b0;
      Out        <= '0;
      Valid_OUT  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
`ifdef FEEDER_FLUSH_EN
      r_flush_cnt <= '0;
`endif
    end else begin
      Valid_OUT  <= r_s1_valid;
      if (r_s1_valid)
        Out <= r_s1_zero ? '0 : Mem_Data;
      r_s1_valid <= 1'b0;
      r_s1_zero  <= 1'b0;
      Done       <= 1'b0;

      case (r_state)
        IDLE: begin
          Busy <= Start;
          if (Start) begin
            r_state   <= READ;
            r_addr    <= Base_Addr;
            r_pix_cnt <= '0;
          end
        end

        READ: begin
          if (!Hold) begin
            r_s1_valid <= 1'b1;
            r_addr     <= r_addr + Addrwidth'(1);
            r_pix_cnt  <= r_pix_cnt + c_PIX_W'(1);
            if (r_pix_cnt == c_LAST_PIX) begin
              r_state <= c_AFTER_RD;
`ifdef FEEDER_FLUSH_EN
              r_flush_cnt <= '0;
`endif
            end
          end
        end

`ifdef FEEDER_FLUSH_EN
        FLUSH: begin
          if (!Hold) begin
            r_s1_valid  <= 1'b1;
            r_s1_zero   <= 1'b1;
            r_flush_cnt <= r_flush_cnt + c_FL_W'(1);
            if (r_flush_cnt == c_LAST_FL)
              r_state <= FINISH;
          end
        end
`endif

        // Entered on the edge that issued the last beat, so stage 1 holds it now
        FINISH: begin
          Done    <= 1'b1;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/feature_map_streamer.md
FEATURE_MAP_STREAMER -- requirements
Module: feature_map_streamer

Interface
REQ-001 SHALL have parameter IMG_Width, default 4: pixels per row.
REQ-002 SHALL have parameter IMG_Height, default 4: rows per image.
REQ-003 SHALL have parameter Datawidth, default 32: pixel width.
REQ-004 SHALL have parameter Addrwidth, default 16: memory address width.
REQ-005 SHALL have parameter Flush_Count, default IMG_Width+1: number of zero pixels appended after the image.
REQ-006 SHALL have port CLK  input  1  the only clock; all logic on its rising edge.
REQ-007 SHALL have port CLR  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port Start  input  1  one-cycle request to stream one image.
REQ-009 SHALL have port Base_Addr  input  Addrwidth  image base address, sampled when Start is accepted.
REQ-010 SHALL have port Hold  input  1  when high, no new memory read is issued.
REQ-011 SHALL have port Mem_RdEn  output  1  memory read strobe.
REQ-012 SHALL have port Mem_Addr  output  Addrwidth  memory read address.
REQ-013 SHALL have port Mem_Data  input  Datawidth  read data, valid exactly one cycle after Mem_RdEn.
REQ-014 SHALL have port Out  output  Datawidth  streamed pixel, raster order, to the convolution Valid_IN/In port.
REQ-015 SHALL have port Valid_OUT  output  1  Out holds a pixel this cycle.
REQ-016 SHALL have port Busy  output  1  a stream is in progress.
REQ-017 SHALL have port Done  output  1  one-cycle pulse on the final output beat.

Function
REQ-018 SHALL implement FSM states IDLE, READ, FLUSH, FINISH.
REQ-019 IDLE->READ SHALL occur on the edge where Start=1, latching Base_Addr and clearing the pixel counter.
REQ-020 Start SHALL be ignored in every state except IDLE.
REQ-021 In READ, Mem_RdEn SHALL equal !Hold (combinational from state), and Mem_Addr SHALL equal latched base + pixel counter.
REQ-022 The pixel counter SHALL advance only on cycles with Mem_RdEn=1; address arithmetic SHALL wrap modulo 2^Addrwidth.
REQ-023 READ->FLUSH SHALL occur on the edge that issues read number IMG_Width*IMG_Height.
REQ-024 In FLUSH, one zero pixel SHALL be injected per cycle with Hold=0 (no memory read), Flush_Count in total; then FLUSH->FINISH.
REQ-025 The output pipeline SHALL be two stages: stage 1 holds the read/flush valid flag, and stage 2 registers Out and Valid_OUT. A read issued in cycle t SHALL appear on Out/Valid_OUT after edge t+2.
REQ-026 Flush pixels SHALL use the same two-cycle latency, with Out=0.
REQ-027 Ordering SHALL be preserved: all image pixels first, then the flush zeros; no gaps except those caused by Hold.
REQ-028 Hold asserted SHALL stop new issues only; a beat already in flight SHALL still be emitted.
REQ-029 FINISH SHALL wait until the pipeline is empty, and SHALL assert Done together with the last Valid_OUT beat before returning to IDLE.
REQ-030 Busy SHALL be 1 from the edge that accepts Start through the edge after Done, and 0 otherwise.
REQ-031 Out SHALL hold its last value when Valid_OUT=0.

Reset
REQ-032 CLR=1 at any edge SHALL force IDLE and zero the counters and pipeline valids. Mem_RdEn, Valid_OUT, Busy and Done SHALL be 0 and Out SHALL be 0 after that edge.
REQ-033 CLR mid-stream SHALL drop in-flight beats without emitting them; a Start arriving while CLR=1 SHALL be ignored.

Configuration
REQ-034 With macro FEEDER_FLUSH_EN defined, the FLUSH state SHALL exist per REQ-024.
REQ-035 Without FEEDER_FLUSH_EN, READ SHALL go directly to FINISH, no zero pixels SHALL be emitted, and Flush_Count SHALL be unused.

Verification
REQ-036 SHALL cover: 4x4, memory[Base+i]=i+1, Base=0x10, Start -> Valid_OUT beats 1..16, then 5 zeros; first beat 2 cycles after acceptance; Done on beat 21 only.
REQ-037 SHALL cover: same stimulus with Hold high for 3 cycles after the 5th read -> identical data sequence, exactly 3 extra gap cycles, no duplicated or lost beats.
REQ-038 SHALL cover: Start pulsed again during READ -> ignored; Base_Addr unchanged; exactly 21 beats.
REQ-039 SHALL cover: CLR asserted after the 7th beat -> Valid_OUT/Busy 0 next cycle; a new Start streams beats 1..16 from the start.
REQ-040 SHALL cover: Base_Addr=0xFFFE, 4x4 -> addresses wrap to 0x0000..0x000D.
REQ-041 SHALL cover: FEEDER_FLUSH_EN undefined -> exactly 16 beats, with Done on beat 16.
